// File: rtl/game_state_fsm_pkg.sv
// Shared game definitions: state encoding, start key and spike count.
// Used by the state FSM, the color mapper and the motion blocks.
package game_state_fsm_pkg;

    localparam int unsigned NUM_SPIKES = 4;
    localparam logic [7:0]  KEY_SPACE_CODE = 8'h2C;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned SCORE_W = 16;
    localparam int unsigned FCNT_W  = 16;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_PLAY  = 2'd1,
        ST_LOST  = 2'd2,
        ST_WON   = 2'd3
    } game_state_e;

    // Increment that sticks at a ceiling instead of wrapping.
    function automatic logic [FCNT_W-1:0] sat_inc(input logic [FCNT_W-1:0] val,
                                                  input logic [FCNT_W-1:0] ceil);
        return (val >= ceil) ? ceil : val + 1'b1;
    endfunction

endpackage

// File: rtl/game_state_fsm_if.sv
// Game-state bundle: frame sync, keyboard, sprite geometry in; status out.
interface game_state_fsm_if;
    import game_state_fsm_pkg::*;

    logic                                frame_clk;
    logic [7:0]                          keycode;
    logic [COORD_W-1:0]                  BallX;
    logic [COORD_W-1:0]                  BallY;
    logic [COORD_W-1:0]                  Ball_size;
    logic [NUM_SPIKES-1:0][COORD_W-1:0]  ObsX;
    logic [NUM_SPIKES-1:0][COORD_W-1:0]  ObsY;
    logic [NUM_SPIKES-1:0][COORD_W-1:0]  Obs_size;
    logic                                S;
    logic                                L;
    logic                                W;
    logic [SCORE_W-1:0]                  Score;
    logic                                collide;

    modport master (
        output frame_clk, keycode, BallX, BallY, Ball_size, ObsX, ObsY, Obs_size,
        input  S, L, W, Score, collide
    );

    modport slave (
        input  frame_clk, keycode, BallX, BallY, Ball_size, ObsX, ObsY, Obs_size,
        output S, L, W, Score, collide
    );

endinterface

// File: rtl/game_state_fsm_box_overlap.sv
// Axis-aligned bounding-box overlap test; edge sums carried at 11 bits
// so boxes near the right/bottom of the 10-bit range never wrap.
module box_overlap
    import game_state_fsm_pkg::*;
(
    input  logic [COORD_W-1:0] a_x,
    input  logic [COORD_W-1:0] a_y,
    input  logic [COORD_W-1:0] a_size,
    input  logic [COORD_W-1:0] b_x,
    input  logic [COORD_W-1:0] b_y,
    input  logic [COORD_W-1:0] b_size,
    output logic               hit
);

    logic [COORD_W:0] a_x_end;
    logic [COORD_W:0] a_y_end;
    logic [COORD_W:0] b_x_end;
    logic [COORD_W:0] b_y_end;
    logic             x_ok;
    logic             y_ok;

    always_comb begin
        a_x_end = {1'b0, a_x} + {1'b0, a_size};
        a_y_end = {1'b0, a_y} + {1'b0, a_size};
        b_x_end = {1'b0, b_x} + {1'b0, b_size};
        b_y_end = {1'b0, b_y} + {1'b0, b_size};
        x_ok    = ({1'b0, a_x} <= b_x_end) && (a_x_end >= {1'b0, b_x});
        y_ok    = ({1'b0, a_y} <= b_y_end) && (a_y_end >= {1'b0, b_y});
        hit     = x_ok && y_ok;
    end

endmodule

// File: rtl/game_state_fsm.sv
// Game flow controller: start screen, play with grace period, lost/won hold.
// All game updates happen on a vsync-derived frame tick; the start key acts immediately.
//
// state    | meaning
// ST_START | press-start screen, waiting for space
// ST_PLAY  | run in progress, score counts frames
// ST_LOST  | bee hit a spike, restart after hold time
// ST_WON   | bee reached the flag, restart after hold time
module game_state_fsm
    import game_state_fsm_pkg::*;
#(
    parameter logic [COORD_W-1:0] WIN_X        = 10'd560,
    parameter int unsigned        GRACE_FRAMES = 30,
    parameter int unsigned        HOLD_FRAMES  = 60,
    parameter logic [7:0]         KEY_SPACE    = KEY_SPACE_CODE
)(
    input  logic             Clk,
    input  logic             Reset_n,
    game_state_fsm_if.slave  bus
);

    localparam logic [FCNT_W-1:0] GRACE_CNT = FCNT_W'(GRACE_FRAMES);
    localparam logic [FCNT_W-1:0] HOLD_CNT  = FCNT_W'(HOLD_FRAMES);

    game_state_e         state_q, state_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic                frame_clk_q;
    logic                armed_q;
    logic [7:0]          keycode_q;
    logic                s_q, s_d;
    logic                l_q, l_d;
    logic                w_q, w_d;

    logic                frame_tick;
    logic                key_press;
    logic [NUM_SPIKES-1:0] spike_hit;
    logic                collide;

    for (genvar i = 0; i < NUM_SPIKES; i++) begin : g_spike
        box_overlap u_overlap (
            .a_x    (bus.BallX),
            .a_y    (bus.BallY),
            .a_size (bus.Ball_size),
            .b_x    (bus.ObsX[i]),
            .b_y    (bus.ObsY[i]),
            .b_size (bus.Obs_size[i]),
            .hit    (spike_hit[i])
        );
    end

    assign collide = |spike_hit;

    // armed_q masks the first post-reset cycle so a vsync already high at
    // release is not mistaken for a rising edge.
    assign frame_tick = armed_q && bus.frame_clk && !frame_clk_q;
    assign key_press  = (bus.keycode == KEY_SPACE) && (keycode_q != KEY_SPACE);

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        frame_cnt_d = frame_cnt_q;

        unique case (state_q)
            ST_START: begin
                if (key_press) begin
                    state_d     = ST_PLAY;
                    score_d     = '0;
                    frame_cnt_d = '0;
                end
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    if ((frame_cnt_q >= GRACE_CNT) && collide) begin
                        state_d     = ST_LOST;
                        frame_cnt_d = '0;
                    end else if (bus.BallX >= WIN_X) begin
                        state_d     = ST_WON;
                        frame_cnt_d = '0;
                    end else begin
                        score_d     = (score_q == '1) ? score_q : score_q + 1'b1;
                        frame_cnt_d = sat_inc(frame_cnt_q, GRACE_CNT);
                    end
                end
            end
            ST_LOST, ST_WON: begin
                // An accepted restart takes precedence over a same-cycle frame tick.
                if (key_press && (frame_cnt_q >= HOLD_CNT)) begin
                    state_d     = ST_START;
                    frame_cnt_d = '0;
                end else if (frame_tick) begin
                    frame_cnt_d = sat_inc(frame_cnt_q, HOLD_CNT);
                end
            end
            default: begin
                state_d     = ST_START;
                frame_cnt_d = '0;
            end
        endcase

        s_d = (state_d == ST_START);
        l_d = (state_d == ST_LOST);
        w_d = (state_d == ST_WON);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q     <= ST_START;
            score_q     <= '0;
            frame_cnt_q <= '0;
            frame_clk_q <= 1'b0;
            armed_q     <= 1'b0;
            keycode_q   <= '0;
            s_q         <= 1'b1;
            l_q         <= 1'b0;
            w_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            frame_cnt_q <= frame_cnt_d;
            frame_clk_q <= bus.frame_clk;
            armed_q     <= 1'b1;
            keycode_q   <= bus.keycode;
            s_q         <= s_d;
            l_q         <= l_d;
            w_q         <= w_d;
        end
    end

    assign bus.S       = s_q;
    assign bus.L       = l_q;
    assign bus.W       = w_q;
    assign bus.Score   = score_q;
    assign bus.collide = collide;

endmodule

// File: tb/tb_game_state_fsm.sv
// Scoreboard bench for game_state_fsm: expected status words are queued with
// each stimulus step and compared against the DUT outputs at the falling edge.
module tb_game_state_fsm;
    import game_state_fsm_pkg::*;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    typedef struct {
        string       tag;
        logic [19:0] exp;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    game_state_fsm_if bus ();

    game_state_fsm dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got S/L/W/col=%b score=%0d, want S/L/W/col=%b score=%0d",
                      tag, obs[19:16], obs[15:0], exp[19:16], exp[15:0]);
    endtask

    task automatic expect_out(input string tag, input bit s, input bit l, input bit w,
                              input bit c, input int score);
        exp_t e;
        e.tag = tag;
        e.exp = {s, l, w, c, 16'(score)};
        sb_q.push_back(e);
    endtask

    task automatic observe();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard: output observed with no expectation queued");
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, {bus.S, bus.L, bus.W, bus.collide, bus.Score}, e.exp);
        end
    endtask

    task automatic do_frame();
        @(negedge clk) bus.frame_clk = 1'b1;
        @(negedge clk) bus.frame_clk = 1'b0;
    endtask

    task automatic do_frames(input int n);
        for (int i = 0; i < n; i++) do_frame();
    endtask

    task automatic press_space();
        @(negedge clk) bus.keycode = KEY_SPACE_CODE;
        @(negedge clk) bus.keycode = 8'h00;
    endtask

    task automatic pulse_reset();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic set_ball(input int x, input int y, input int sz);
        bus.BallX     = 10'(x);
        bus.BallY     = 10'(y);
        bus.Ball_size = 10'(sz);
    endtask

    task automatic set_spike(input int i, input int x, input int y, input int sz);
        bus.ObsX[i]     = 10'(x);
        bus.ObsY[i]     = 10'(y);
        bus.Obs_size[i] = 10'(sz);
    endtask

    task automatic set_idle();
        set_ball(0, 0, 10);
        for (int i = 0; i < NUM_SPIKES; i++) set_spike(i, 500, 400, 10);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.frame_clk = 1'b0;
        bus.keycode   = 8'h00;
        set_idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_out("reset", 1, 0, 0, 0, 0);
        observe();

        // Held space: one press, one PLAY entry, score keeps counting
        @(negedge clk) bus.keycode = KEY_SPACE_CODE;
        do_frames(5);
        expect_out("held_key", 0, 0, 0, 0, 5);
        observe();
        @(negedge clk) bus.keycode = 8'h00;
        @(negedge clk) bus.keycode = KEY_SPACE_CODE;
        @(negedge clk) bus.keycode = 8'h00;
        do_frame();
        expect_out("repress_in_play", 0, 0, 0, 0, 6);
        observe();

        // Overlap ignored inside grace, fatal on frame 31
        set_ball(100, 200, 40);
        set_spike(0, 120, 220, 30);
        do_frames(4);
        expect_out("grace_f10", 0, 0, 0, 1, 10);
        observe();
        do_frames(20);
        expect_out("grace_f30", 0, 0, 0, 1, 30);
        observe();
        do_frame();
        expect_out("lost_f31", 0, 1, 0, 1, 30);
        observe();
        do_frames(3);
        expect_out("lost_hold", 0, 1, 0, 1, 30);
        observe();

        set_idle();
        pulse_reset();
        expect_out("reset_in_lost", 1, 0, 0, 0, 0);
        observe();

        // Collision beats win on the same frame
        press_space();
        do_frames(30);
        expect_out("run2_f30", 0, 0, 0, 0, 30);
        observe();
        set_ball(560, 0, 10);
        set_spike(1, 565, 5, 10);
        do_frame();
        expect_out("collide_over_win", 0, 1, 0, 1, 30);
        observe();

        // Win, then restart hold boundary
        set_idle();
        pulse_reset();
        press_space();
        do_frames(4);
        bus.BallX = 10'd559;
        do_frame();
        expect_out("x559_play", 0, 0, 0, 0, 5);
        observe();
        bus.BallX = 10'd560;
        do_frame();
        expect_out("won", 0, 0, 1, 0, 5);
        observe();
        do_frames(59);
        press_space();
        expect_out("hold59_ignored", 0, 0, 1, 0, 5);
        observe();
        do_frame();
        press_space();
        expect_out("hold60_restart", 1, 0, 0, 0, 5);
        observe();

        // Overlap near the top of the 10-bit range
        @(negedge clk);
        set_ball(1000, 100, 40);
        set_spike(2, 1020, 110, 10);
        #1;
        expect_out("edge_x_overlap", 1, 0, 0, 1, 5);
        observe();
        set_ball(10, 100, 40);
        set_spike(2, 1000, 100, 30);
        #1;
        expect_out("edge_no_wrap", 1, 0, 0, 0, 5);
        observe();
        set_idle();
        set_ball(100, 1000, 40);
        set_spike(3, 110, 1020, 10);
        #1;
        expect_out("edge_y_overlap", 1, 0, 0, 1, 5);
        observe();

        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/game_state_fsm.md
GAME_STATE_FSM -- requirements
Module: game_state_fsm

Interface
REQ-001 SHALL have parameter WIN_X, default 10'd560; bee X position at or beyond which the game is won.
REQ-002 SHALL have parameter GRACE_FRAMES, default 30; frames after entering PLAY during which collisions are ignored.
REQ-003 SHALL have parameter HOLD_FRAMES, default 60; minimum frames spent in LOST/WON before restart is accepted.
REQ-004 SHALL have parameter KEY_SPACE, default 8'h2C; start/restart keycode.
REQ-005 SHALL have port Clk, input, 1, system clock; single clock domain.
REQ-006 SHALL have port Reset_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have port frame_clk, input, 1, VGA vertical sync; a frame tick is its rising edge.
REQ-008 SHALL have port keycode, input, 8, current USB keycode (8'h00 = none).
REQ-009 SHALL have port BallX, BallY, Ball_size, input, 10 each, bee sprite origin and extent.
REQ-010 SHALL have port ObsX, ObsY, Obs_size, input, 4x10 each, origins and extents of spikes 0..3.
REQ-011 SHALL have port S, output, 1, start screen active (press-start sprite shown).
REQ-012 SHALL have port L, output, 1, game lost (bee hidden, game-over text shown).
REQ-013 SHALL have port W, output, 1, game won (flag shown).
REQ-014 SHALL have port Score, output, 16, frames survived in the current run.
REQ-015 SHALL have port collide, output, 1, combinational overlap of bee with any spike (debug).

Function
REQ-016 SHALL register frame_clk and generate a one-Clk-cycle frame_tick on its 0->1 transition; all game state updates occur only on frame_tick, except reset.
REQ-017 SHALL register keycode and generate key_press for one cycle when keycode becomes KEY_SPACE from any other value; a held key does not repeat.
REQ-018 SHALL compute overlap per spike as BallX <= ObsX+Obs_size && BallX+Ball_size >= ObsX && the same in Y, all sums at 11 bits (no wrap); collide = OR of the four.
REQ-019 SHALL implement states START, PLAY, LOST, WON; S=1 only in START, L=1 only in LOST, W=1 only in WON; outputs are registered, one-hot or all zero.
REQ-020 START: on key_press -> PLAY, clear Score and frame counter; key_press is accepted at any cycle, not only on frame_tick.
REQ-021 PLAY: on frame_tick, Score increments, saturating at 16'hFFFF; frame counter increments, saturating at GRACE_FRAMES.
REQ-022 PLAY: on frame_tick with frame counter >= GRACE_FRAMES and collide=1 -> LOST; else if BallX >= WIN_X -> WON; collision has priority when both hold in the same frame.
REQ-023 PLAY: Score SHALL not increment on the frame_tick that causes the transition to LOST or WON.
REQ-024 Entering LOST or WON SHALL clear the frame counter; it then increments per frame_tick, saturating at HOLD_FRAMES.
REQ-025 LOST/WON: key_press with frame counter >= HOLD_FRAMES -> START; earlier key_press is ignored; Score holds its final value until the next START->PLAY.
REQ-026 SHALL react to a key_press and a frame_tick in the same cycle by applying the key_press transition only.

Reset
REQ-027 On Clk edge with Reset_n=0: state=START, S=1, L=0, W=0, Score=0, frame counter=0, edge-detect registers=0; this applies mid-game in any state.
REQ-028 The first frame_clk rising edge after reset release SHALL produce a frame_tick only if frame_clk was sampled 0 after release.

Structure
REQ-029 State enum (START, PLAY, LOST, WON), KEY_SPACE and the spike count 4 SHALL live in the shared game package used by the color mapper and the motion blocks.
REQ-030 Bounding-box overlap SHALL be a sub-module box_overlap, instantiated four times.

Verification
REQ-031 Reset, then keycode 8'h2C held for 5 frames -> S=0 after one press, one PLAY entry only; release and re-press in PLAY has no effect.
REQ-032 PLAY, bee at (100,200) size 40, spike 0 at (120,220) size 30, frame 10 -> stays PLAY; the same overlap at frame 31 -> L=1, Score=30.
REQ-033 PLAY, BallX=560 with overlap on the same frame after the grace period -> L=1, W=0.
REQ-034 PLAY, BallX=560 with no overlap -> W=1; space at hold frame 59 is ignored; space at frame 60 -> S=1, Score still held.
REQ-035 Ball_size=40, ObsX=1000 near 10-bit limit -> no false overlap from wrap.
REQ-036 Reset_n=0 for one cycle while in LOST -> next cycle S=1, L=0, Score=0.
